wb_sram_burst: RTL and testbench
================================

# wb_sram_burst

Parametrised Wishbone B4 pipelined-classic SRAM slave, successor to the single-word picosoc RAM wrapper. It supports configurable data width and depth, byte-lane writes, and a single, correctly terminated acknowledge per classic cycle. It adds out-of-range error termination and registered-feedback incrementing/wrapping bursts at one beat per clock. It sits on the SoC Wishbone interconnect as CPU-local RAM and frame scratch buffer.

## Interface
- DATA_WIDTH, 32: data bus width; 32 or 64.
- MEM_WORDS, 256: depth in DATA_WIDTH words; power of two, ≥16.
- ADR_WIDTH, 32: byte address width.
- wb_clk_i  in  1  clock; all state on rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- wb_adr_i  in  ADR_WIDTH  byte address; word index = adr[ADR_WIDTH-1:LSB], where LSB = log2(DATA_WIDTH/8).
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  DATA_WIDTH/8  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i, wb_stb_i  in  1  cycle and strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  DATA_WIDTH  read data; valid only while wb_ack_o=1.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error termination.

## Operation
- Request = wb_cyc_i & wb_stb_i. The address is in range when word index < MEM_WORDS, with all upper bits zero.
- FSM has three states:
  - IDLE: on an in-range request, issue the RAM read at wb_adr_i and go to ACK. On an out-of-range request, go to ERR.
  - ACK: wb_ack_o=1 for this cycle.
    - If request & cti=010 & same we, go to ACK again.
    - Otherwise go to IDLE, which forces ack low for at least one cycle. A classic cycle with stb held yields exactly one ack.
  - ERR: wb_err_o=1 for one cycle, then IDLE. No RAM write occurs.
- Write commit happens in the cycle where wb_ack_o=1 & wb_we_i=1.
  - RAM lane i is written from wb_dat_i when wb_sel_i[i] is set.
  - The write address is the master's current wb_adr_i.
- Burst read prefetch: in ACK with a continuing burst, the RAM read address is next(adr).
  - Linear: word index + 1.
  - Wrap-N: the low log2(N) bits of the word index increment modulo N; upper bits are held.
  - The next beat's data is therefore ready at the following ack.
- The burst ends on cti=111: ack that beat and return to IDLE.
- A continuing burst whose next address is out of range goes to ERR instead of ACK.
- Deassertion of stb or cyc in ACK returns the FSM to IDLE. A later re-strobe restarts as a new access (2-cycle latency).
- wb_dat_o holds its last value when ack is low; no zeroing is required.
- Simultaneous reset and request: reset wins; the request is ignored.

## Timing
- Reset values: wb_ack_o=0, wb_err_o=0, FSM=IDLE, wb_dat_o=0. RAM contents are not cleared.
- Reset mid-burst drops ack and err asynchronously. A write in the same cycle is not committed.
- Classic read or write: request at cycle T, ack at T+1, idle at T+2. Throughput is one access per 2 cycles.
- Burst of N beats: first ack at T+1, then one ack per cycle. The last ack is at T+N.
- Error: err at T+1, single cycle.
- Read-after-write to the same word in consecutive classic cycles returns the new data.

## Configuration
- WB_SRAM_BURST_EN defined:
  - Burst handling is as described.
- WB_SRAM_BURST_EN undefined:
  - wb_cti_i and wb_bte_i are ignored.
  - Every access is classic: ACK always returns to IDLE.
  - The prefetch and wrap logic is removed.
  - Error behaviour is identical.

## Test plan
- Reset release, then classic write 0xDEADBEEF to 0x10 with sel=1111, stb held 4 cycles -> exactly one ack, at T+1. Reading 0x10 returns 0xDEADBEEF.
- Write 0x11223344 to 0x20 with sel=0101, after first writing 0xFFFFFFFF -> read returns 0xFF22FF44.
- Linear burst read of 4 beats from 0x0, cti=010,010,010,111 -> acks on 4 consecutive cycles. Data are words 0..3, then ack drops.
- Wrap4 burst starting at word 6 -> data order is words 6, 7, 4, 5. With the macro undefined, the same stimulus yields acks every other cycle only.
- Read of word MEM_WORDS (0x400 for defaults) -> err at T+1, no ack. A write to the same address leaves RAM unchanged.
- wb_rst_ni pulsed low mid-burst at beat 2 -> ack=0 immediately. Words already written retain their data, and the next classic access completes normally.

Source files
------------

// File: rtl/wb_sram_burst.sv
`default_nettype none
// ============================================================================
// Module   : wb_sram_burst
// Purpose  : Wishbone B4 pipelined-classic SRAM slave with byte-lane writes,
//            out-of-range error termination and optional registered-feedback
//            incrementing/wrapping bursts at one beat per clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   WB_SRAM_BURST_EN  defined   -> cti/bte honoured, bursts ack every clock
//                     undefined -> every access is classic (ack then idle)
// ----------------------------------------------------------------------------
// Ports:
//   wb_clk_i   in   clock, all state on rising edge
//   wb_rst_ni  in   asynchronous active-low reset
//   wb_adr_i   in   byte address (word index = adr[ADR_WIDTH-1:LSB])
//   wb_dat_i   in   write data
//   wb_sel_i   in   byte enables
//   wb_we_i    in   write enable
//   wb_cyc_i   in   bus cycle
//   wb_stb_i   in   strobe
//   wb_cti_i   in   cycle type (000 classic, 010 incrementing, 111 end)
//   wb_bte_i   in   burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//   wb_dat_o   out  read data, meaningful while wb_ack_o is high
//   wb_ack_o   out  acknowledge
//   wb_err_o   out  error termination
// ============================================================================
module wb_sram_burst #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 256,
   parameter int ADR_WIDTH  = 32
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic [ADR_WIDTH-1:0]    wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                    wb_we_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic [2:0]              wb_cti_i,
   input  logic [1:0]              wb_bte_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o
);

   localparam int c_sel_w = DATA_WIDTH / 8;
   localparam int c_lsb   = $clog2(c_sel_w);
   localparam int c_aw    = $clog2(MEM_WORDS);
   localparam int c_iw    = ADR_WIDTH - c_lsb;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0] r_dat;
   logic                  w_req;
   logic                  w_in_range;
   logic                  w_rd_en;
   logic                  w_wr_en;
   logic [c_iw-1:0]       w_idx;
   logic [c_aw-1:0]       w_rd_idx;
   logic                  w_unused;

   assign w_req      = wb_cyc_i & wb_stb_i;
   assign w_idx      = wb_adr_i[ADR_WIDTH-1:c_lsb];
   // In range only when every index bit above the RAM depth is zero.
   assign w_in_range = (w_idx[c_iw-1:c_aw] == '0);

`ifdef WB_SRAM_BURST_EN
   logic [c_iw-1:0] w_nxt_idx;
   logic            w_nxt_in_range;
   logic            w_burst_go;
   logic            r_we;

   // Address of the beat after the one currently on the bus. Wrap bursts
   // only roll the low log2(N) index bits; the upper bits stay put.
   always_comb begin
      w_nxt_idx = w_idx + c_iw'(1);
      case (wb_bte_i)
         2'b01:   w_nxt_idx = {w_idx[c_iw-1:2], w_idx[1:0] + 2'd1};
         2'b10:   w_nxt_idx = {w_idx[c_iw-1:3], w_idx[2:0] + 3'd1};
         2'b11:   w_nxt_idx = {w_idx[c_iw-1:4], w_idx[3:0] + 4'd1};
         default: w_nxt_idx = w_idx + c_iw'(1);
      endcase
   end

   assign w_nxt_in_range = (w_nxt_idx[c_iw-1:c_aw] == '0);
   // A burst only continues while the direction matches the first beat.
   assign w_burst_go     = w_req & (wb_cti_i == 3'b010) & (wb_we_i == r_we);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_we <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_req) begin
         r_we <= wb_we_i;
      end
   end

   assign w_unused = ^wb_adr_i[c_lsb-1:0];
`else
   assign w_unused = ^{wb_adr_i[c_lsb-1:0], wb_cti_i, wb_bte_i};
`endif

   // ------------------------------------------------------------------------
   // FSM: next state, RAM read control and bus terminations
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_rd_en      = 1'b0;
      w_rd_idx     = w_idx[c_aw-1:0];
      wb_ack_o     = 1'b0;
      wb_err_o     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (w_in_range) begin
                  w_next_state = ST_ACK;
                  w_rd_en      = 1'b1;
               end else begin
                  w_next_state = ST_ERR;
               end
            end
         end
         ST_ACK: begin
            wb_ack_o     = 1'b1;
            // Dropping back to idle guarantees ack low for a cycle, so a
            // classic master never sees two acks for one strobe.
            w_next_state = ST_IDLE;
`ifdef WB_SRAM_BURST_EN
            if (w_burst_go) begin
               if (w_nxt_in_range) begin
                  // Prefetch the next beat so its data is ready at next ack.
                  w_next_state = ST_ACK;
                  w_rd_en      = 1'b1;
                  w_rd_idx     = w_nxt_idx[c_aw-1:0];
               end else begin
                  w_next_state = ST_ERR;
               end
            end
`endif
         end
         ST_ERR: begin
            wb_err_o     = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Writes commit on the acked beat, at the master's current address.
   assign w_wr_en = (r_state == ST_ACK) & wb_we_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= ST_IDLE;
         r_dat   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_rd_en) begin
            r_dat <= r_mem[w_rd_idx];
         end
      end
   end

   // RAM array is deliberately not reset.
   always_ff @(posedge wb_clk_i) begin
      if (w_wr_en) begin
         for (int i = 0; i < c_sel_w; i++) begin
            if (wb_sel_i[i]) begin
               r_mem[w_idx[c_aw-1:0]][i*8 +: 8] <= wb_dat_i[i*8 +: 8];
            end
         end
      end
   end

   assign wb_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_sram_burst
// Purpose  : Scoreboard bench for wb_sram_burst. A bus master issues random
//            and directed classic/burst transfers, pushing the expected
//            response per beat; a monitor pops and compares on ack/err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sram_burst;

   localparam int DW = 32;
   localparam int MW = 256;
   localparam int AW = 32;
   localparam int SW = DW / 8;
`ifdef WB_SRAM_BURST_EN
   localparam bit BURST_HW = 1'b1;
`else
   localparam bit BURST_HW = 1'b0;
`endif

   logic          wb_clk_i  = 1'b0;
   logic          wb_rst_ni = 1'b0;
   logic [AW-1:0] wb_adr_i  = '0;
   logic [DW-1:0] wb_dat_i  = '0;
   logic [SW-1:0] wb_sel_i  = '0;
   logic          wb_we_i   = 1'b0;
   logic          wb_cyc_i  = 1'b0;
   logic          wb_stb_i  = 1'b0;
   logic [2:0]    wb_cti_i  = 3'b000;
   logic [1:0]    wb_bte_i  = 2'b00;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;

   wb_sram_burst #(
      .DATA_WIDTH(DW),
      .MEM_WORDS (MW),
      .ADR_WIDTH (AW)
   ) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_ni(wb_rst_ni),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_cti_i (wb_cti_i),
      .wb_bte_i (wb_bte_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct packed {
      logic          err;
      logic          we;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [DW-1:0] model_mem [MW];
   int            vectors     = 0;
   int            miscompares = 0;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Word address of beat i of a transfer starting at word s.
   function automatic int beat_word(input int s, input int i, input logic [1:0] bte, input bit burst);
      int n;
      if (!burst) return s;
      case (bte)
         2'b01:   n = 4;
         2'b10:   n = 8;
         2'b11:   n = 16;
         default: n = 0;
      endcase
      if (n == 0) return s + i;
      return (s - (s % n)) + (((s % n) + i) % n);
   endfunction

   // ------------------------------------------------------------------------
   // Monitor: every ack/err consumes one expectation
   // ------------------------------------------------------------------------
   always @(negedge wb_clk_i) begin
      if (wb_rst_ni && (wb_ack_o || wb_err_o)) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_response: ack=%0b err=%0b with no transfer outstanding",
                     wb_ack_o, wb_err_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_is_err", DW'(wb_err_o), DW'(mon_e.err));
            if (!mon_e.err && !mon_e.we && wb_ack_o)
               check("read_data", wb_dat_o, mon_e.data);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Master: one call = one classic access or one burst. Entered and left
   // just after a rising edge. rst_beat >= 0 pulses reset during that beat.
   // ------------------------------------------------------------------------
   task automatic xfer(input int s, input int n, input bit we, input logic [1:0] bte,
                       input bit burst, input bit rnd, input logic [DW-1:0] d0,
                       input logic [SW-1:0] s0, input int rst_beat);
      for (int i = 0; i < n; i++) begin
         int            w;
         int            waited;
         bit            got;
         bit            was_err;
         logic [DW-1:0] d;
         logic [SW-1:0] sl;
         exp_t          e;
         w  = beat_word(s, i, bte, burst);
         d  = rnd ? DW'($urandom) : d0;
         sl = rnd ? SW'($urandom_range(1, (1 << SW) - 1)) : s0;
         wb_adr_i = AW'(w * SW);
         wb_dat_i = d;
         wb_sel_i = sl;
         wb_we_i  = we;
         wb_cyc_i = 1'b1;
         wb_stb_i = 1'b1;
         wb_bte_i = bte;
         wb_cti_i = burst ? ((i == n - 1) ? 3'b111 : 3'b010) : 3'b000;
         e.err  = (w >= MW);
         e.we   = we;
         e.data = (w < MW) ? model_mem[w] : '0;
         exp_q.push_back(e);
         waited  = 0;
         got     = 1'b0;
         was_err = 1'b0;
         while (!got && waited < 16) begin
            @(negedge wb_clk_i);
            waited++;
            if (wb_ack_o || wb_err_o) begin
               got     = 1'b1;
               was_err = wb_err_o;
            end
         end
         if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: word %0d got no response within 16 cycles", w);
            break;
         end
         // Bursting hardware acks follow-on beats back to back; every other
         // beat pays the idle->ack latency.
         check("beat_latency", DW'(waited), DW'((BURST_HW && burst && i > 0) ? 1 : 2));
         if (i == rst_beat) begin
            #2 wb_rst_ni = 1'b0;
            #1 check("async_reset_drop", DW'({wb_ack_o, wb_err_o}), '0);
            @(posedge wb_clk_i);
            #1;
            wb_rst_ni = 1'b1;
            wb_cyc_i  = 1'b0;
            wb_stb_i  = 1'b0;
            wb_we_i   = 1'b0;
            wb_cti_i  = 3'b000;
            check("dat_after_reset", wb_dat_o, '0);
            return;
         end
         if (!was_err && we && w < MW)
            for (int b = 0; b < SW; b++)
               if (sl[b]) model_mem[w][b*8 +: 8] = d[b*8 +: 8];
         @(posedge wb_clk_i);
         #1;
         if (was_err) break;
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_cti_i = 3'b000;
      wb_bte_i = 2'b00;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Request held during reset must be ignored.
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      check("reset_ack", DW'(wb_ack_o), '0);
      check("reset_err", DW'(wb_err_o), '0);
      check("reset_dat", wb_dat_o, '0);
      @(posedge wb_clk_i);
      #1;
      wb_cyc_i  = 1'b0;
      wb_stb_i  = 1'b0;
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i);
      #1;

      // Give every word a known value.
      for (int w = 0; w < MW; w++)
         xfer(w, 1, 1'b1, 2'b00, 1'b0, 1'b0, DW'($urandom), {SW{1'b1}}, -1);

      // Directed: full write/read, partial lanes, bursts.
      xfer(4, 1, 1'b1, 2'b00, 1'b0, 1'b0, 32'hDEADBEEF, 4'hF, -1);
      xfer(4, 1, 1'b0, 2'b00, 1'b0, 1'b0, '0, 4'hF, -1);
      xfer(8, 1, 1'b1, 2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 4'hF, -1);
      xfer(8, 1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h11223344, 4'b0101, -1);
      xfer(8, 1, 1'b0, 2'b00, 1'b0, 1'b0, '0, 4'hF, -1);
      xfer(0, 4, 1'b0, 2'b00, 1'b1, 1'b0, '0, 4'hF, -1);
      xfer(6, 4, 1'b0, 2'b01, 1'b1, 1'b0, '0, 4'hF, -1);
      xfer(13, 8, 1'b1, 2'b10, 1'b1, 1'b1, '0, 4'hF, -1);
      xfer(13, 8, 1'b0, 2'b10, 1'b1, 1'b0, '0, 4'hF, -1);
      xfer(37, 16, 1'b0, 2'b11, 1'b1, 1'b0, '0, 4'hF, -1);

      // Out of range: read, write (must not alias), then word 0 unchanged.
      xfer(MW, 1, 1'b0, 2'b00, 1'b0, 1'b0, '0, 4'hF, -1);
      xfer(MW, 1, 1'b1, 2'b00, 1'b0, 1'b0, 32'hA5A5A5A5, 4'hF, -1);
      xfer(0, 1, 1'b0, 2'b00, 1'b0, 1'b0, '0, 4'hF, -1);
      // Linear burst running off the end of the RAM.
      xfer(MW - 2, 4, 1'b0, 2'b00, 1'b1, 1'b0, '0, 4'hF, -1);

      // Random mix.
      for (int t = 0; t < 40; t++) begin
         int          kind;
         logic [1:0]  bte;
         int          len;
         kind = $urandom_range(0, 3);
         case (kind)
            0: xfer($urandom_range(0, MW - 1), 1, 1'b0, 2'b00, 1'b0, 1'b1, '0, '0, -1);
            1: xfer($urandom_range(0, MW - 1), 1, 1'b1, 2'b00, 1'b0, 1'b1, '0, '0, -1);
            2: xfer($urandom_range(0, MW - 8), $urandom_range(1, 8), 1'($urandom_range(0, 1)),
                    2'b00, 1'b1, 1'b1, '0, '0, -1);
            default: begin
               bte = 2'($urandom_range(1, 3));
               len = $urandom_range(1, 4 << (bte - 1));
               xfer($urandom_range(0, MW - 1), len, 1'($urandom_range(0, 1)),
                    bte, 1'b1, 1'b1, '0, '0, -1);
            end
         endcase
      end

      // Reset pulsed during beat 2 of a write burst; beat 2 must not land.
      xfer(20, 4, 1'b1, 2'b00, 1'b1, 1'b1, '0, '0, 2);
      for (int w = 20; w < 24; w++)
         xfer(w, 1, 1'b0, 2'b00, 1'b0, 1'b0, '0, 4'hF, -1);
      xfer(20, 4, 1'b0, 2'b00, 1'b1, 1'b0, '0, 4'hF, -1);

      repeat (4) @(posedge wb_clk_i);
      check("scoreboard_drained", DW'(exp_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
